ucie_ctl_sb_tx_fsm: RTL and testbench
=====================================

UCIE_CTL_SB_TX_FSM -- requirements
Module: UCIE_ctl_sb_tx_fsm

Interface
REQ-001 Parameter CRD_MAX, default 1, is the number of sideband message credits held at reset; the credit counter saturates at this value.
REQ-002 i_clk  input  1  the single clock; all state changes on the rising edge.
REQ-003 i_rst  input  1  reset, asynchronous and active-high.
REQ-004 i_valid_lp_sb  input  1  request strobe; sampled only while o_lp_sb_rdy=1.
REQ-005 i_lp_sb_decode  input  5  message select: [4]=no-data, [3:2]=msgcode select, [1:0]=subcode select.
REQ-006 i_lp_adv_cap_value  input  32  payload for the with-data message.
REQ-007 i_count_done  input  1  serializer has finished shifting the current 32-bit word.
REQ-008 i_cfg_crd  input  1  one-cycle credit-return pulse from the far side.
REQ-009 o_pl_cfg_vld  output  1  transfer in progress, high PHASE_0 through the last phase.
REQ-010 o_tx_data  output  32  current phase word, registered.
REQ-011 o_lp_sb_rdy  output  1  equals (state==IDLE) and (credits>0).
REQ-012 o_tx_done  output  1  one-cycle pulse when a message completes.
REQ-013 o_sb_tx_error  output  1  one-cycle pulse when an accepted request is an illegal decode.

Function
REQ-014 The FSM SHALL have states IDLE, PHASE_0, PHASE_1, PHASE_2, PHASE_3, DONE.
REQ-015 A request accepted in IDLE with a legal decode SHALL move to PHASE_0 on the next edge; o_pl_cfg_vld=1 and o_tx_data=phase-0 word from that cycle on, with one credit consumed.
REQ-016 Each PHASE_n SHALL hold its word until i_count_done=1, then advance on the next edge with the next word; the step after the last phase goes to DONE.
REQ-017 DONE SHALL last one cycle with o_pl_cfg_vld=0, o_tx_done=1 and o_tx_data=0, then return to IDLE.
REQ-018 Phase 0 SHALL be built as: [4:0] opcode (5'b11011 with data, 5'b10010 no-data); [21:14] msgcode; [31:29] srcid=3'b001; all other bits 0.
REQ-019 Phase 1 SHALL be built as: [7:0] subcode; [23:8]=0; [26:24] dstid=3'b101; [29:27]=0; [30] CP=XOR of phase0[31:0] and phase1[29:0]; [31] DP=XOR of all 64 payload bits.
REQ-020 Phase 2 SHALL be i_lp_adv_cap_value as captured at accept, and phase 3 SHALL be 32'h0; for no-data messages both SHALL be 0 and DP=0.
REQ-021 The legal decode map SHALL be:
- 5'b00000 -> msgcode 0x01, subcode 0x00 (with data).
- [4]=1 with [3:2]=01 -> msgcode 0x03; [3:2]=10 -> 0x04; subcode select 01 -> 0x01, 11 -> 0x09.
- [4]=1 with [3:2]=11 -> msgcode 0x09, subcode select 00/01/10 -> 0x00/0x01/0x02.
- Every other code is illegal.
REQ-022 An illegal decode SHALL pulse o_sb_tx_error the next cycle, stay in IDLE, consume no credit and transmit nothing.
REQ-023 The decode and payload SHALL be latched at accept; input changes mid-message SHALL have no effect.
REQ-024 i_cfg_crd SHALL increment the credit count, saturating at CRD_MAX; a simultaneous accept and return SHALL leave the count unchanged.
REQ-025 i_count_done in IDLE or DONE SHALL be ignored.

Reset
REQ-026 While i_rst=1, state SHALL be IDLE, credits SHALL be CRD_MAX, and every output SHALL be 0 except o_lp_sb_rdy=1.
REQ-027 Reset asserted mid-message SHALL abort immediately with no o_tx_done pulse.

Configuration
REQ-028 With UCIE_SB_TX_SHORT_MSG_EN defined, no-data messages SHALL go PHASE_1 -> DONE on i_count_done; without it, every message SHALL send all four phases (REQ-020).

Verification
REQ-029 Decode 5'b10101 -> o_tx_data 0x2000C012, then 0x05000001, then 0x0, then 0x0 (macro off), then one o_tx_done pulse.
REQ-030 Decode 5'b00000 with payload 0x00000001 -> 0x2000401B, 0x85000000, 0x00000001, 0x00000000.
REQ-031 CRD_MAX=1: second request before i_cfg_crd -> o_lp_sb_rdy=0, no transfer; after an i_cfg_crd pulse -> rdy=1 and the request is accepted.
REQ-032 Decode 5'b10100 -> o_sb_tx_error pulse, o_pl_cfg_vld stays 0, credits unchanged.
REQ-033 i_rst during PHASE_2 -> o_pl_cfg_vld=0 and IDLE at once, credits=CRD_MAX, no o_tx_done.
REQ-034 Macro on, decode 5'b11110 -> exactly two words (0x20024012, 0x05000002), then o_tx_done.

Source files
------------

// File: rtl/ucie_ctl_sb_tx_fsm.sv
// Sideband TX message sequencer: decodes a request, then emits four 32-bit phase words with credit flow control.
// Optional UCIE_SB_TX_SHORT_MSG_EN: no-data messages end after phase 1.
module ucie_ctl_sb_tx_fsm #(
    parameter int unsigned CRD_MAX = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid_lp_sb,
    input  logic [4:0]  i_lp_sb_decode,
    input  logic [31:0] i_lp_adv_cap_value,
    input  logic        i_count_done,
    input  logic        i_cfg_crd,
    output logic        o_pl_cfg_vld,
    output logic [31:0] o_tx_data,
    output logic        o_lp_sb_rdy,
    output logic        o_tx_done,
    output logic        o_sb_tx_error
);

    localparam int unsigned CRD_W   = (CRD_MAX < 2) ? 1 : $clog2(CRD_MAX + 1);
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned CODE_W  = 8;

    localparam logic [CRD_W-1:0] CRD_FULL = CRD_W'(CRD_MAX);
    localparam logic [CRD_W-1:0] CRD_ONE  = CRD_W'(1);
    localparam logic [CRD_W-1:0] CRD_ZERO = CRD_W'(0);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] PHASE_0 = 3'd1;
    localparam logic [2:0] PHASE_1 = 3'd2;
    localparam logic [2:0] PHASE_2 = 3'd3;
    localparam logic [2:0] PHASE_3 = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    localparam logic [4:0] OPC_DATA   = 5'b11011;
    localparam logic [4:0] OPC_NODATA = 5'b10010;
    localparam logic [2:0] SRC_ID     = 3'b001;
    localparam logic [2:0] DST_ID     = 3'b101;

    localparam logic [1:0] SEL_P0 = 2'd0;
    localparam logic [1:0] SEL_P1 = 2'd1;
    localparam logic [1:0] SEL_P2 = 2'd2;
    localparam logic [1:0] SEL_P3 = 2'd3;

    // Assemble one phase word; parity bits cover the header and the 64-bit payload.
    function automatic logic [WORD_W-1:0] build_word(
        input logic [1:0]        sel,
        input logic              nodata,
        input logic [CODE_W-1:0] msg,
        input logic [CODE_W-1:0] sub,
        input logic [WORD_W-1:0] payload
    );
        logic [WORD_W-1:0]   p0;
        logic [WORD_W-1:0]   p1;
        logic [2*WORD_W-1:0] pay64;
        logic [WORD_W-1:0]   word;
        pay64      = nodata ? 64'h0 : {32'h0, payload};
        p0         = 32'h0;
        p0[4:0]    = nodata ? OPC_NODATA : OPC_DATA;
        p0[21:14]  = msg;
        p0[31:29]  = SRC_ID;
        p1         = 32'h0;
        p1[7:0]    = sub;
        p1[26:24]  = DST_ID;
        p1[30]     = ^{p0, p1[29:0]};
        p1[31]     = ^pay64;
        case (sel)
            SEL_P0:  word = p0;
            SEL_P1:  word = p1;
            SEL_P2:  word = pay64[31:0];
            default: word = pay64[63:32];
        endcase
        return word;
    endfunction

    logic [2:0]        state, state_n;
    logic [CRD_W-1:0]  crd_q, crd_n;

    logic              nodata_q;
    logic [CODE_W-1:0] msg_q;
    logic [CODE_W-1:0] sub_q;
    logic [WORD_W-1:0] pay_q;
    logic              latch_en;

    logic              vld_q, vld_n;
    logic [WORD_W-1:0] data_q, data_n;
    logic              done_q, done_n;
    logic              err_q, err_n;
    logic              rdy_q, rdy_n;

    logic              dec_legal;
    logic [CODE_W-1:0] dec_msg;
    logic [CODE_W-1:0] dec_sub;
    logic              accept;
    logic              consume;

    // Legal message map; everything not listed is rejected.
    always_comb begin
        dec_legal = 1'b0;
        dec_msg   = 8'h00;
        dec_sub   = 8'h00;
        if (i_lp_sb_decode == 5'b00000) begin
            dec_legal = 1'b1;
            dec_msg   = 8'h01;
        end else if (i_lp_sb_decode[4]) begin
            case (i_lp_sb_decode[3:2])
                2'b01, 2'b10: begin
                    dec_msg = (i_lp_sb_decode[3:2] == 2'b01) ? 8'h03 : 8'h04;
                    case (i_lp_sb_decode[1:0])
                        2'b01: begin
                            dec_legal = 1'b1;
                            dec_sub   = 8'h01;
                        end
                        2'b11: begin
                            dec_legal = 1'b1;
                            dec_sub   = 8'h09;
                        end
                        default: dec_legal = 1'b0;
                    endcase
                end
                2'b11: begin
                    dec_msg   = 8'h09;
                    dec_legal = (i_lp_sb_decode[1:0] != 2'b11);
                    dec_sub   = {6'b0, i_lp_sb_decode[1:0]};
                end
                default: dec_legal = 1'b0;
            endcase
        end
    end

    assign accept = (state == IDLE) && rdy_q && i_valid_lp_sb;

    // Next state and next registered outputs.
    always_comb begin
        state_n  = state;
        vld_n    = vld_q;
        data_n   = data_q;
        done_n   = 1'b0;
        err_n    = 1'b0;
        latch_en = 1'b0;
        consume  = 1'b0;
        case (state)
            IDLE: begin
                vld_n  = 1'b0;
                data_n = 32'h0;
                if (accept) begin
                    if (dec_legal) begin
                        state_n  = PHASE_0;
                        vld_n    = 1'b1;
                        data_n   = build_word(SEL_P0, i_lp_sb_decode[4], dec_msg, dec_sub,
                                              i_lp_adv_cap_value);
                        latch_en = 1'b1;
                        consume  = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            PHASE_0: begin
                if (i_count_done) begin
                    state_n = PHASE_1;
                    data_n  = build_word(SEL_P1, nodata_q, msg_q, sub_q, pay_q);
                end
            end
            PHASE_1: begin
                if (i_count_done) begin
`ifdef UCIE_SB_TX_SHORT_MSG_EN
                    if (nodata_q) begin
                        state_n = DONE;
                        vld_n   = 1'b0;
                        data_n  = 32'h0;
                        done_n  = 1'b1;
                    end else begin
                        state_n = PHASE_2;
                        data_n  = build_word(SEL_P2, nodata_q, msg_q, sub_q, pay_q);
                    end
`else
                    state_n = PHASE_2;
                    data_n  = build_word(SEL_P2, nodata_q, msg_q, sub_q, pay_q);
`endif
                end
            end
            PHASE_2: begin
                if (i_count_done) begin
                    state_n = PHASE_3;
                    data_n  = build_word(SEL_P3, nodata_q, msg_q, sub_q, pay_q);
                end
            end
            PHASE_3: begin
                if (i_count_done) begin
                    state_n = DONE;
                    vld_n   = 1'b0;
                    data_n  = 32'h0;
                    done_n  = 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
                vld_n   = 1'b0;
                data_n  = 32'h0;
            end
            default: begin
                state_n = IDLE;
                vld_n   = 1'b0;
                data_n  = 32'h0;
            end
        endcase
    end

    // Credit counter: a return in the same cycle as an accept cancels out.
    always_comb begin
        crd_n = crd_q;
        if (consume && !i_cfg_crd) begin
            crd_n = crd_q - CRD_ONE;
        end else if (!consume && i_cfg_crd && (crd_q != CRD_FULL)) begin
            crd_n = crd_q + CRD_ONE;
        end
        rdy_n = (state_n == IDLE) && (crd_n != CRD_ZERO);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= IDLE;
            crd_q  <= CRD_FULL;
            vld_q  <= 1'b0;
            data_q <= 32'h0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            rdy_q  <= (CRD_FULL != CRD_ZERO);
        end else begin
            state  <= state_n;
            crd_q  <= crd_n;
            vld_q  <= vld_n;
            data_q <= data_n;
            done_q <= done_n;
            err_q  <= err_n;
            rdy_q  <= rdy_n;
        end
    end

    // Request fields frozen at accept so later input changes cannot disturb the message.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            nodata_q <= 1'b0;
            msg_q    <= 8'h00;
            sub_q    <= 8'h00;
            pay_q    <= 32'h0;
        end else if (latch_en) begin
            nodata_q <= i_lp_sb_decode[4];
            msg_q    <= dec_msg;
            sub_q    <= dec_sub;
            pay_q    <= i_lp_adv_cap_value;
        end
    end

    assign o_pl_cfg_vld  = vld_q;
    assign o_tx_data     = data_q;
    assign o_lp_sb_rdy   = rdy_q;
    assign o_tx_done     = done_q;
    assign o_sb_tx_error = err_q;

endmodule

// File: tb/tb_ucie_ctl_sb_tx_fsm.sv
// Bench for ucie_ctl_sb_tx_fsm: fixed vectors, hand sequences for credits/reset, and random messages vs. a message-level model.
module tb_ucie_ctl_sb_tx_fsm;

    localparam int unsigned CRD = 1;
`ifdef UCIE_SB_TX_SHORT_MSG_EN
    localparam bit SHORT = 1'b1;
`else
    localparam bit SHORT = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        valid;
    logic [4:0]  decode;
    logic [31:0] payload;
    logic        count_done;
    logic        cfg_crd;
    logic        pl_cfg_vld;
    logic [31:0] tx_data;
    logic        lp_sb_rdy;
    logic        tx_done;
    logic        sb_tx_error;

    int checks;
    int failures;
    int model_crd;

    ucie_ctl_sb_tx_fsm #(.CRD_MAX(CRD)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_valid_lp_sb      (valid),
        .i_lp_sb_decode     (decode),
        .i_lp_adv_cap_value (payload),
        .i_count_done       (count_done),
        .i_cfg_crd          (cfg_crd),
        .o_pl_cfg_vld       (pl_cfg_vld),
        .o_tx_data          (tx_data),
        .o_lp_sb_rdy        (lp_sb_rdy),
        .o_tx_done          (tx_done),
        .o_sb_tx_error      (sb_tx_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  code;
        logic [7:0]  msg;
        logic [7:0]  sub;
    } leg_t;

    typedef struct {
        logic [4:0]  dec;
        logic [31:0] pay;
        bit          legal;
        bit          nodata;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
    } vec_t;

    leg_t legal_tab[8];
    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Message-level reference: table lookup for legality, arithmetic for fields and parity.
    function automatic void model(input logic [4:0] dec, input logic [31:0] pay,
                                  output bit legal, output bit nodata,
                                  output logic [3:0][31:0] w);
        logic [7:0]  msg;
        logic [7:0]  sub;
        logic [63:0] data64;
        int          cp;
        int          dp;
        legal = 1'b0;
        msg   = 8'h0;
        sub   = 8'h0;
        for (int i = 0; i < 8; i++) begin
            if (legal_tab[i].code == dec) begin
                legal = 1'b1;
                msg   = legal_tab[i].msg;
                sub   = legal_tab[i].sub;
            end
        end
        nodata = dec[4];
        data64 = nodata ? 64'h0 : {32'h0, pay};
        w[0]   = 32'h2000_0000 + ({24'h0, msg} << 14) + (nodata ? 32'd18 : 32'd27);
        w[1]   = 32'h0500_0000 + {24'h0, sub};
        cp     = ($countones(w[0]) + $countones(w[1])) % 2;
        dp     = $countones(data64) % 2;
        w[1]   = w[1] + 32'(cp) * 32'h4000_0000 + 32'(dp) * 32'h8000_0000;
        w[2]   = data64[31:0];
        w[3]   = data64[63:32];
    endfunction

    task automatic pulse_crd();
        cfg_crd    = 1'b1;
        count_done = 1'($urandom_range(0, 1));
        @(negedge clk);
        cfg_crd    = 1'b0;
        count_done = 1'b0;
        if (model_crd < int'(CRD)) model_crd++;
    endtask

    // Issue one request from IDLE and follow it to completion, checking every cycle.
    task automatic run_msg(input logic [4:0] dec, input logic [31:0] pay, input bit legal,
                           input bit nodata, input logic [3:0][31:0] w, input bit ret_at_accept,
                           input string tag);
        int n;
        int gap;
        chk({tag, "_rdy_in"}, 32'(lp_sb_rdy), 32'(model_crd > 0));
        valid   = 1'b1;
        decode  = dec;
        payload = pay;
        cfg_crd = ret_at_accept;
        @(negedge clk);
        valid   = 1'b0;
        cfg_crd = 1'b0;
        decode  = 5'($urandom);
        payload = $urandom;
        if (!legal) begin
            if (ret_at_accept && model_crd < int'(CRD)) model_crd++;
            chk({tag, "_err"}, 32'(sb_tx_error), 32'd1);
            chk({tag, "_err_vld"}, 32'(pl_cfg_vld), 32'd0);
            chk({tag, "_err_data"}, tx_data, 32'h0);
            @(negedge clk);
            chk({tag, "_err_clr"}, 32'(sb_tx_error), 32'd0);
            chk({tag, "_err_rdy"}, 32'(lp_sb_rdy), 32'(model_crd > 0));
            return;
        end
        if (!ret_at_accept) model_crd--;
        n = (SHORT && nodata) ? 2 : 4;
        chk({tag, "_noerr"}, 32'(sb_tx_error), 32'd0);
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s_vld%0d", tag, k), 32'(pl_cfg_vld), 32'd1);
            chk($sformatf("%s_w%0d", tag, k), tx_data, w[k]);
            chk($sformatf("%s_busy_rdy%0d", tag, k), 32'(lp_sb_rdy), 32'd0);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                chk($sformatf("%s_hold%0d", tag, k), tx_data, w[k]);
            end
            count_done = 1'b1;
            @(negedge clk);
            count_done = 1'b0;
        end
        chk({tag, "_done"}, 32'(tx_done), 32'd1);
        chk({tag, "_done_vld"}, 32'(pl_cfg_vld), 32'd0);
        chk({tag, "_done_data"}, tx_data, 32'h0);
        count_done = 1'($urandom_range(0, 1));
        @(negedge clk);
        count_done = 1'b0;
        chk({tag, "_done_clr"}, 32'(tx_done), 32'd0);
        chk({tag, "_rdy_out"}, 32'(lp_sb_rdy), 32'(model_crd > 0));
    endtask

    initial begin
        logic [3:0][31:0] w;
        logic [4:0]       d;
        logic [31:0]      p;
        bit               lg;
        bit               nd;

        checks     = 0;
        failures   = 0;
        model_crd  = int'(CRD);
        rst        = 1'b1;
        valid      = 1'b0;
        decode     = 5'h0;
        payload    = 32'h0;
        count_done = 1'b0;
        cfg_crd    = 1'b0;

        legal_tab[0] = '{5'b00000, 8'h01, 8'h00};
        legal_tab[1] = '{5'b10101, 8'h03, 8'h01};
        legal_tab[2] = '{5'b10111, 8'h03, 8'h09};
        legal_tab[3] = '{5'b11001, 8'h04, 8'h01};
        legal_tab[4] = '{5'b11011, 8'h04, 8'h09};
        legal_tab[5] = '{5'b11100, 8'h09, 8'h00};
        legal_tab[6] = '{5'b11101, 8'h09, 8'h01};
        legal_tab[7] = '{5'b11110, 8'h09, 8'h02};

        vecs[0]  = '{5'b10101, 32'hDEADBEEF, 1, 1, 32'h2000C012, 32'h05000001, 32'h0, 32'h0};
        vecs[1]  = '{5'b00000, 32'h00000001, 1, 0, 32'h2000401B, 32'h85000000, 32'h1, 32'h0};
        vecs[2]  = '{5'b11110, 32'h00001234, 1, 1, 32'h20024012, 32'h05000002, 32'h0, 32'h0};
        vecs[3]  = '{5'b10111, 32'h0000FFFF, 1, 1, 32'h2000C012, 32'h45000009, 32'h0, 32'h0};
        vecs[4]  = '{5'b11001, 32'h12345678, 1, 1, 32'h20010012, 32'h45000001, 32'h0, 32'h0};
        vecs[5]  = '{5'b00000, 32'hFFFFFFFF, 1, 0, 32'h2000401B, 32'h05000000, 32'hFFFFFFFF, 32'h0};
        vecs[6]  = '{5'b10100, 32'h0, 0, 1, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[7]  = '{5'b01000, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[8]  = '{5'b11111, 32'h0, 0, 1, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[9]  = '{5'b11100, 32'h00000007, 1, 1, 32'h20024012, 32'h45000000, 32'h0, 32'h0};
        vecs[10] = '{5'b11011, 32'h0, 1, 1, 32'h20010012, 32'h05000009, 32'h0, 32'h0};

        // Reset values while reset is held
        #12;
        chk("rst_vld", 32'(pl_cfg_vld), 32'd0);
        chk("rst_data", tx_data, 32'h0);
        chk("rst_done", 32'(tx_done), 32'd0);
        chk("rst_err", 32'(sb_tx_error), 32'd0);
        chk("rst_rdy", 32'(lp_sb_rdy), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Fixed vectors
        for (int i = 0; i < 11; i++) begin
            w = {vecs[i].w3, vecs[i].w2, vecs[i].w1, vecs[i].w0};
            run_msg(vecs[i].dec, vecs[i].pay, vecs[i].legal, vecs[i].nodata, w, 1'b0,
                    $sformatf("vec%0d", i));
            if (model_crd == 0) pulse_crd();
        end

        // Out of credits: requests are ignored until a credit returns
        model(5'b10101, 32'h0, lg, nd, w);
        run_msg(5'b10101, 32'h0, lg, nd, w, 1'b0, "drain");
        valid  = 1'b1;
        decode = 5'b00000;
        for (int i = 0; i < 3; i++) begin
            chk("nocrd_rdy", 32'(lp_sb_rdy), 32'd0);
            @(negedge clk);
            chk("nocrd_vld", 32'(pl_cfg_vld), 32'd0);
            chk("nocrd_err", 32'(sb_tx_error), 32'd0);
        end
        valid = 1'b0;
        pulse_crd();
        chk("crd_back_rdy", 32'(lp_sb_rdy), 32'd1);
        model(5'b00000, 32'h00000001, lg, nd, w);
        run_msg(5'b00000, 32'h00000001, lg, nd, w, 1'b0, "after_crd");
        pulse_crd();

        // Return coinciding with accept keeps the count; extra returns saturate
        model(5'b11101, 32'h0, lg, nd, w);
        run_msg(5'b11101, 32'h0, lg, nd, w, 1'b1, "crd_simul");
        pulse_crd();
        pulse_crd();
        model(5'b00000, 32'hCAFE0001, lg, nd, w);
        run_msg(5'b00000, 32'hCAFE0001, lg, nd, w, 1'b0, "crd_sat");
        pulse_crd();

        // Reset in PHASE_2 aborts the message without a done pulse
        valid   = 1'b1;
        decode  = 5'b00000;
        payload = 32'hA5A5A5A5;
        @(negedge clk);
        valid      = 1'b0;
        count_done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        count_done = 1'b0;
        chk("abort_p2_data", tx_data, 32'hA5A5A5A5);
        chk("abort_p2_vld", 32'(pl_cfg_vld), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_vld", 32'(pl_cfg_vld), 32'd0);
        chk("abort_data", tx_data, 32'h0);
        chk("abort_done", 32'(tx_done), 32'd0);
        chk("abort_rdy", 32'(lp_sb_rdy), 32'd1);
        @(negedge clk);
        rst       = 1'b0;
        model_crd = int'(CRD);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_nodone", 32'(tx_done), 32'd0);
        end
        model(5'b11110, 32'h0, lg, nd, w);
        run_msg(5'b11110, 32'h0, lg, nd, w, 1'b0, "post_abort");
        pulse_crd();

        // Random requests against the model
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 1) == 1) d = legal_tab[$urandom_range(0, 7)].code;
            else d = 5'($urandom);
            p = $urandom;
            model(d, p, lg, nd, w);
            run_msg(d, p, lg, nd, w, ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", it));
            if (model_crd == 0 || $urandom_range(0, 2) == 0) pulse_crd();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
